// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package md_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH + 1);

  localparam logic MD_OP_MULT = 1'b0;
  localparam logic MD_OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/md_sequencer_if.sv
// Request/result bundle between the control unit and md_sequencer.
// Build option MD_WRITE_PORT_EN adds the hi_we/lo_we/wdata mthi/mtlo write port.
interface md_sequencer_if
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) ();

  // Handshake: start is a one-cycle request that is accepted only while busy
  // is low; there is no back-pressure and no queueing. done pulses for one
  // cycle when hi_out/lo_out hold the new result; div_zero qualifies done.
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

`ifdef MD_WRITE_PORT_EN
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;

  modport master (
    output start, op, a_in, b_in, hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi_out, lo_out
  );

  modport slave (
    input  start, op, a_in, b_in, hi_we, lo_we, wdata,
    output busy, done, div_zero, hi_out, lo_out
  );
`else
  modport master (
    output start, op, a_in, b_in,
    input  busy, done, div_zero, hi_out, lo_out
  );

  modport slave (
    input  start, op, a_in, b_in,
    output busy, done, div_zero, hi_out, lo_out
  );
`endif

endinterface

// File: rtl/md_div_step.sv
// One restoring-division iteration on unsigned magnitudes:
// shift the next dividend bit into the remainder and subtract if it fits.
module md_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The remainder stays below the divisor, so the shifted value fits in
  // WIDTH+1 bits and diff's top bit is exactly the borrow.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    if (diff[WIDTH]) begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) producing HI/LO.
// Build option MD_WRITE_PORT_EN enables direct HI/LO writes while idle.
module md_sequencer
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  md_sequencer_if.slave bus,
  output md_state_e     dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_e        state_q;
  md_state_e        state_d;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             q_m1;
  logic             sign_a;
  logic             sign_b;
  logic             dz_q;

  logic             accept;
  logic             b_zero;
  logic             last_step;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign accept    = (state_q == ST_IDLE) && bus.start;
  assign b_zero    = (bus.b_in == '0);
  assign last_step = (cnt == CW'(1));
  assign a_mag     = bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
  assign b_mag     = bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;

  // Booth step: the add/sub is one bit wider than P_hi so that the
  // arithmetic shift takes its sign from the true partial product.
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   hi_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH-1:0] booth_hi;
  logic [WIDTH-1:0] booth_lo;

  always_comb begin
    m_ext  = {operand[WIDTH-1], operand};
    hi_ext = {acc_hi[WIDTH-1], acc_hi};
    case ({acc_lo[0], q_m1})
      2'b01:   booth_sum = hi_ext + m_ext;
      2'b10:   booth_sum = hi_ext - m_ext;
      default: booth_sum = hi_ext;
    endcase
    booth_hi = booth_sum[WIDTH:1];
    booth_lo = {booth_sum[0], acc_lo[WIDTH-1:1]};
  end

  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  md_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (acc_hi),
    .quo      (acc_lo),
    .divisor  (operand),
    .rem_next (div_rem),
    .quo_next (div_quo)
  );

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign quo_fix = (sign_a ^ sign_b) ? -div_quo : div_quo;
  assign rem_fix = sign_a ? -div_rem : div_rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.op == MD_OP_MULT) begin
            state_d = ST_MULT;
          end else if (!b_zero) begin
            state_d = ST_DIV;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_MULT: if (last_step) state_d = ST_DONE;
      ST_DIV:  if (last_step) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      operand <= '0;
      q_m1    <= 1'b0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          dz_q <= 1'b0;
`ifdef MD_WRITE_PORT_EN
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
`endif
          if (accept) begin
            cnt  <= CW'(WIDTH);
            q_m1 <= 1'b0;
            if (bus.op == MD_OP_MULT) begin
              acc_hi  <= '0;
              acc_lo  <= bus.a_in;
              operand <= bus.b_in;
            end else if (!b_zero) begin
              acc_hi  <= '0;
              acc_lo  <= a_mag;
              operand <= b_mag;
              sign_a  <= bus.a_in[WIDTH-1];
              sign_b  <= bus.b_in[WIDTH-1];
            end else begin
              dz_q <= 1'b1;
            end
          end
        end
        ST_MULT: begin
          acc_hi <= booth_hi;
          acc_lo <= booth_lo;
          q_m1   <= acc_lo[0];
          cnt    <= cnt - CW'(1);
          if (last_step) begin
            hi_q <= booth_hi;
            lo_q <= booth_lo;
          end
        end
        ST_DIV: begin
          acc_hi <= div_rem;
          acc_lo <= div_quo;
          cnt    <= cnt - CW'(1);
          if (last_step) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.div_zero = (state_q == ST_DONE) && dz_q;
  assign bus.hi_out   = hi_q;
  assign bus.lo_out   = lo_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer with a latency/arithmetic reference model.
// Build option MD_WRITE_PORT_EN also exercises the HI/LO write port.
module tb_md_sequencer;
  import md_pkg::*;

  localparam int W = 32;

  logic      clk = 1'b0;
  logic      reset;
  md_state_e dbg_state;

  md_sequencer_if #(.WIDTH(W)) bus ();

  md_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model_hi(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sb;
    longint v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == MD_OP_MULT) v = (sa * sb) >>> W;
    else                 v = sa % sb;
    return v[W-1:0];
  endfunction

  function automatic logic [W-1:0] model_lo(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sb;
    longint v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == MD_OP_MULT) v = sa * sb;
    else                 v = sa / sb;
    return v[W-1:0];
  endfunction

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_hi;
  logic [W-1:0] exp_lo;
  logic         exp_busy;
  logic         exp_done;
  logic         exp_dz;
  int           left;

  // left counts the remaining busy cycles of the accepted operation.
  always @(posedge clk) begin
    if (reset) begin
      left     <= 0;
      exp_hi   <= '0;
      exp_lo   <= '0;
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
      exp_dz   <= 1'b0;
      exp_q.delete();
    end else if (left == 0) begin
`ifdef MD_WRITE_PORT_EN
      if (bus.hi_we) exp_hi <= bus.wdata;
      if (bus.lo_we) exp_lo <= bus.wdata;
`endif
      if (bus.start) begin
        exp_busy <= 1'b1;
        if (bus.op == MD_OP_DIV && bus.b_in == '0) begin
          left     <= 1;
          exp_done <= 1'b1;
          exp_dz   <= 1'b1;
        end else begin
          left <= W + 1;
          exp_q.push_back(model_hi(bus.op, bus.a_in, bus.b_in));
          exp_q.push_back(model_lo(bus.op, bus.a_in, bus.b_in));
        end
      end
    end else begin
      left <= left - 1;
      if (left == 2) begin
        exp_done <= 1'b1;
        exp_hi   <= exp_q.pop_front();
        exp_lo   <= exp_q.pop_front();
      end
      if (left == 1) begin
        exp_busy <= 1'b0;
        exp_done <= 1'b0;
        exp_dz   <= 1'b0;
      end
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check_bit("cyc_busy", bus.busy, exp_busy);
      check_bit("cyc_done", bus.done, exp_done);
      check_bit("cyc_div_zero", bus.div_zero, exp_dz);
      check("cyc_hi", bus.hi_out, exp_hi);
      check("cyc_lo", bus.lo_out, exp_lo);
    end
  end

  // ---------------- driver ----------------
  task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int pulse_at, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a_in  = a;
    bus.b_in  = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 1'($urandom_range(0, 1));
    bus.a_in  = $urandom;
    bus.b_in  = $urandom;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (lat == pulse_at) begin
        bus.start = 1'b1;
        bus.op    = MD_OP_DIV;
        bus.b_in  = '0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
  endtask

  int lat;

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
`ifdef MD_WRITE_PORT_EN
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
`endif
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_bit("rst_busy", bus.busy, 1'b0);
    check_bit("rst_done", bus.done, 1'b0);
    check("rst_hi", bus.hi_out, 32'h0);
    check("rst_lo", bus.lo_out, 32'h0);
    check_int("rst_state", int'(dbg_state), int'(ST_IDLE));

    run_op(MD_OP_MULT, 32'h00000007, 32'hFFFFFFFD, -1, lat);
    check_int("mul_7x-3_latency", lat, 33);
    check("mul_7x-3_hi", bus.hi_out, 32'hFFFFFFFF);
    check("mul_7x-3_lo", bus.lo_out, 32'hFFFFFFEB);
    @(negedge clk);
    check_bit("mul_7x-3_busy_after", bus.busy, 1'b0);

    run_op(MD_OP_MULT, 32'h80000000, 32'h80000000, -1, lat);
    check("mul_min_sq_hi", bus.hi_out, 32'h40000000);
    check("mul_min_sq_lo", bus.lo_out, 32'h00000000);
    run_op(MD_OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, -1, lat);
    check_int("mul_b2b_latency", lat, 33);
    check("mul_max_sq_hi", bus.hi_out, 32'h3FFFFFFF);
    check("mul_max_sq_lo", bus.lo_out, 32'h00000001);

    run_op(MD_OP_DIV, 32'hFFFFFFF9, 32'h00000002, -1, lat);
    check_int("div_latency", lat, 33);
    check("div_-7/2_lo", bus.lo_out, 32'hFFFFFFFD);
    check("div_-7/2_hi", bus.hi_out, 32'hFFFFFFFF);
    run_op(MD_OP_DIV, 32'h00000007, 32'hFFFFFFFE, -1, lat);
    check("div_7/-2_lo", bus.lo_out, 32'hFFFFFFFD);
    check("div_7/-2_hi", bus.hi_out, 32'h00000001);
    run_op(MD_OP_DIV, 32'h80000000, 32'hFFFFFFFF, -1, lat);
    check("div_min/-1_lo", bus.lo_out, 32'h80000000);
    check("div_min/-1_hi", bus.hi_out, 32'h00000000);
    check_bit("div_min/-1_flag", bus.div_zero, 1'b0);

    // Preset HI = 0x12345678, LO = 0, then divide by zero.
    run_op(MD_OP_MULT, 32'h48D159E0, 32'h40000000, -1, lat);
    check("preset_hi", bus.hi_out, 32'h12345678);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = MD_OP_DIV;
    bus.a_in  = 32'd5;
    bus.b_in  = 32'd0;
    @(negedge clk);
    check_bit("dz_done_k1", bus.done, 1'b1);
    check_bit("dz_flag_k1", bus.div_zero, 1'b1);
    bus.op   = MD_OP_MULT;
    bus.a_in = 32'd3;
    bus.b_in = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    check_bit("dz_done_k2", bus.done, 1'b0);
    check_bit("dz_flag_k2", bus.div_zero, 1'b0);
    check_bit("dz_second_start_ignored", bus.busy, 1'b0);
    check("dz_hi_kept", bus.hi_out, 32'h12345678);
    check("dz_lo_kept", bus.lo_out, 32'h00000000);

    // Reset in the middle of a multiply.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = MD_OP_MULT;
    bus.a_in  = 32'd3;
    bus.b_in  = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    check_int("mid_state_mult", int'(dbg_state), int'(ST_MULT));
    for (int i = 1; i < 10; i++) @(negedge clk);
    check_bit("pre_reset_busy", bus.busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_bit("post_reset_busy", bus.busy, 1'b0);
    check("post_reset_hi", bus.hi_out, 32'h0);
    check("post_reset_lo", bus.lo_out, 32'h0);
    check_int("post_reset_state", int'(dbg_state), int'(ST_IDLE));

    // A start pulse mid-operation must not disturb the running multiply.
    run_op(MD_OP_MULT, 32'h00000064, 32'hFFFFFF9C, 5, lat);
    check_int("pulse_latency", lat, 33);
    check("pulse_hi", bus.hi_out, 32'hFFFFFFFF);
    check("pulse_lo", bus.lo_out, 32'hFFFFD8F0);

`ifdef MD_WRITE_PORT_EN
    @(negedge clk);
    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.wdata = 32'hDEADBEEF;
    @(negedge clk);
    bus.hi_we = 1'b0;
    check("wr_hi_idle", bus.hi_out, 32'hDEADBEEF);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h11111111;
    bus.start = 1'b1;
    bus.op    = MD_OP_MULT;
    bus.a_in  = 32'd2;
    bus.b_in  = 32'd3;
    @(negedge clk);
    bus.lo_we = 1'b0;
    bus.start = 1'b0;
    check("wr_lo_with_start", bus.lo_out, 32'h11111111);
    check_bit("wr_start_accepted", bus.busy, 1'b1);
    bus.hi_we = 1'b1;
    bus.wdata = 32'hCAFEF00D;
    @(negedge clk);
    bus.hi_we = 1'b0;
    check("wr_hi_busy_ignored", bus.hi_out, 32'hDEADBEEF);
    lat = 2;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_int("wr_mult_latency", lat, 33);
    check("wr_mult_hi", bus.hi_out, 32'h0);
    check("wr_mult_lo", bus.lo_out, 32'h6);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multicycle multiply/divide controller and datapath for the CPU; produces the HI/LO values, which are currently tied to zero.
- Sits beside the ALU and takes operands from RegA/RegB.
- Control unit issues a one-cycle `start` with `op`, waits on `busy`/`done`, then selects `hi_out`/`lo_out` through the MemToReg mux.
- Division by zero is flagged so the control unit can vector to exception address 255.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request pulse; sampled only in IDLE
- op  in  1  0 = signed mult, 1 = signed div
- a_in  in  WIDTH  multiplicand / dividend (RegA)
- b_in  in  WIDTH  multiplier / divisor (RegB)
- busy  out  1  high in MULT, DIV, DONE
- done  out  1  one-cycle pulse; HI/LO valid from this cycle
- div_zero  out  1  one-cycle pulse coincident with done when divisor = 0
- hi_out  out  WIDTH  HI register
- lo_out  out  WIDTH  LO register

Behaviour:
- One clock, clk. Reset is synchronous and active-high on `reset`.
- Reset (any state, including mid-operation):
  - state = IDLE, counter = 0
  - hi_out = lo_out = 0, busy = done = div_zero = 0
  - any partial result is discarded.
- FSM states: IDLE, MULT, DIV, DONE.
- IDLE:
  - `start=1` at edge k latches a_in, b_in and op. a_in/b_in are don't-care afterwards.
  - op=0 → MULT, counter = WIDTH.
  - op=1 with b_in ≠ 0 → DIV, counter = WIDTH.
  - op=1 with b_in = 0 → DONE directly, with div_zero set.
- MULT: radix-2 signed Booth.
  - Product register is {P_hi[WIDTH], P_lo[WIDTH], q-1}.
  - Per cycle: examine {P_lo[0], q-1}; 01 → P_hi += M, 10 → P_hi −= M. The add/subtract is WIDTH+1 bits wide with sign-extended M.
  - Then arithmetic right shift of the whole register; counter −1.
  - When counter reaches 0: HI ← P_hi, LO ← P_lo, go to DONE.
- DIV: restoring division on magnitudes |a|, |b|, one quotient bit per cycle, WIDTH cycles.
  - On the edge leaving DIV, apply sign fixup:
    - quotient negated if sign(a) ≠ sign(b), i.e. truncated toward zero;
    - remainder takes the sign of a.
  - LO ← quotient, HI ← remainder.
  - Special case −2^(WIDTH−1) / −1: LO = 0x80000000, HI = 0, no flag.
- DONE: done = 1 for exactly one cycle, then IDLE unconditionally.
  - If div_zero is set: hi_out/lo_out keep their previous values.
- Latency, start sampled at edge k:
  - mult/div: done high during cycle k+WIDTH+1 (33 for WIDTH=32).
  - divide-by-zero: done and div_zero high during cycle k+1.
- Request handling:
  - `start` while busy is ignored and not queued.
  - Back-to-back: a new start is accepted in the IDLE cycle following DONE.
- hi_out/lo_out are registers. They hold between completions and never show intermediate values.
- op is ignored except when start is accepted.

Optional Feature:
- Macro: MD_WRITE_PORT_EN, for mthi/mtlo.
- Defined: adds inputs `hi_we` (1), `lo_we` (1) and `wdata` (WIDTH).
  - In IDLE, `hi_we`/`lo_we` load hi_out/lo_out from wdata on the next edge.
  - Writes are ignored while busy.
  - If start and a write occur in the same IDLE cycle, the write is applied and the start is still accepted.
- Undefined: ports absent; HI/LO are written only by completed operations.

Decomposition:
- Package md_pkg holds:
  - state encoding (IDLE = 2'd0, MULT = 2'd1, DIV = 2'd2, DONE = 2'd3)
  - op codes MD_OP_MULT = 1'b0, MD_OP_DIV = 1'b1
  - default WIDTH = 32
  - counter width $clog2(WIDTH+1).
- One natural sub-module: md_div_step, the combinational restoring step {rem, quo} → next {rem, quo}. The Booth step stays inline.

Test Plan:
- mult 7 × −3 (0x00000007, 0xFFFFFFFD) → done at k+33; HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; busy high cycles k+1..k+33.
- mult 0x80000000 × 0x80000000 → HI = 0x40000000, LO = 0x00000000; then 0x7FFFFFFF × 0x7FFFFFFF → HI = 0x3FFFFFFF, LO = 0x00000001.
- div −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; div 7 / −2 → LO = 0xFFFFFFFD, HI = 0x00000001; div 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- HI = 0x12345678 preset by a prior mult, then div 5 / 0 → done and div_zero high at k+1 only; HI/LO unchanged; second start at k+1 ignored.
- start mult, reset at k+10 → next cycle busy = 0, hi_out = lo_out = 0; start pulsed at k+5 mid-operation has no effect on the result of an un-reset run.
- MD_WRITE_PORT_EN: hi_we with wdata = 0xDEADBEEF in IDLE → hi_out = 0xDEADBEEF next cycle; same write while busy → ignored.
